// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
// Sums a run of `len` consecutive valid 16-bit products into one wide result.
// The result is presented on a valid/ready handshake and held until accepted.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle pulse that begins a dot product (honoured in IDLE only)
//   len        - number of terms, clamped to N_TERMS, sampled with start
//   p_valid    - p_data carries a valid product this cycle
//   p_data     - unsigned 16-bit product from the multiplier
//   busy       - high while accumulating or holding a result
//   sum_valid  - accumulated result available on sum_data
//   sum_data   - unsigned accumulated result
//   sum_ready  - sink accepts the result
//   overrun    - sticky, a product arrived while the block was not accepting
module dot_product_accumulator #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 19,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             p_valid,
  input  logic [15:0]      p_data,
  output logic             busy,
  output logic             sum_valid,
  output logic [ACC_W-1:0] sum_data,
  input  logic             sum_ready,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(N_TERMS);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] sum_data_r;
  logic [ACC_W-1:0] p_ext_s;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] len_q_r;
  logic [LEN_W-1:0] len_clamp_s;
  logic             last_term_s;
  logic             busy_r;
  logic             sum_valid_r;
  logic             overrun_r;
  logic             busy_nxt_s;
  logic             sum_valid_nxt_s;

  // Clamp the requested length to the number of terms the accumulator is sized for.
  always_comb begin
    if (len > MAX_LEN) begin
      len_clamp_s = MAX_LEN;
    end else begin
      len_clamp_s = len;
    end
  end

  // Zero-extend the product and detect the final term of the run.
  always_comb begin
    p_ext_s     = {{(ACC_W-16){1'b0}}, p_data};
    last_term_s = (state_r == ACC) && p_valid && (cnt_r == (len_q_r - LEN_W'(1)));
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len_clamp_s == '0) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = ACC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (last_term_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACC;
        end
      end
      DONE: begin
        if (sum_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered flags track the state register.
  always_comb begin
    busy_nxt_s      = (state_nxt_s != IDLE);
    sum_valid_nxt_s = (state_nxt_s == DONE);
  end

  // State register plus registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      sum_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      busy_r      <= busy_nxt_s;
      sum_valid_r <= sum_valid_nxt_s;
    end
  end

  // Accumulator, term counter, latched length and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= '0;
      cnt_r      <= '0;
      len_q_r    <= '0;
      sum_data_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r   <= '0;
            cnt_r   <= '0;
            len_q_r <= len_clamp_s;
            if (len_clamp_s == '0) begin
              sum_data_r <= '0;
            end
          end
        end
        ACC: begin
          if (p_valid) begin
            acc_r <= acc_r + p_ext_s;
            cnt_r <= cnt_r + LEN_W'(1);
            if (last_term_s) begin
              sum_data_r <= acc_r + p_ext_s;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky overrun; a stray product wins over a same-cycle clear so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (p_valid && ((state_r == IDLE) || (state_r == DONE))) begin
      overrun_r <= 1'b1;
    end else if ((state_r == IDLE) && start) begin
      overrun_r <= 1'b0;
    end
  end

  assign busy      = busy_r;
  assign sum_valid = sum_valid_r;
  assign sum_data  = sum_data_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_dot_product_accumulator.sv
module tb_dot_product_accumulator;

  localparam int N_TERMS = 8;
  localparam int ACC_W   = 19;
  localparam int LEN_W   = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             p_valid;
  logic [15:0]      p_data;
  logic             busy;
  logic             sum_valid;
  logic [ACC_W-1:0] sum_data;
  logic             sum_ready;
  logic             overrun;

  int n_checks = 0;
  int n_pass   = 0;

  // Products to be fed for the next run; reference sum is computed from this queue.
  int unsigned prod_q[$];
  bit          exp_ovr;

  dot_product_accumulator #(
    .N_TERMS(N_TERMS),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .p_valid  (p_valid),
    .p_data   (p_data),
    .busy     (busy),
    .sum_valid(sum_valid),
    .sum_data (sum_data),
    .sum_ready(sum_ready),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: start, feed min(len,N) products with random gaps, hold off
  // the sink for ready_delay cycles, then accept.
  task automatic do_run(input int len_in, input int max_gap, input int ready_delay,
                        input bit inject_start, input bit inject_ovr);
    int          n;
    int unsigned exp_sum;
    int          gaps;
    n = (len_in > N_TERMS) ? N_TERMS : len_in;
    exp_sum = 0;
    for (int i = 0; i < n; i++) exp_sum += prod_q[i];

    start = 1'b1; len = LEN_W'(len_in); p_valid = 1'b0; sum_ready = 1'b0;
    step();
    start = 1'b0;
    exp_ovr = 1'b0;
    check_value("busy_after_start", busy, 1);
    check_value("ovr_cleared_by_start", overrun, 0);

    if (n == 0) begin
      check_value("len0_valid", sum_valid, 1);
      check_value("len0_data", sum_data, 0);
    end
    for (int i = 0; i < n; i++) begin
      gaps = $urandom_range(0, max_gap);
      for (int g = 0; g < gaps; g++) begin
        p_valid = 1'b0;
        step();
        check_value("gap_no_valid", sum_valid, 0);
      end
      p_valid = 1'b1;
      p_data  = prod_q[i][15:0];
      if (inject_start && i == n / 2) begin
        start = 1'b1;
        len   = LEN_W'($urandom_range(0, 15));
      end
      step();
      p_valid = 1'b0;
      start   = 1'b0;
      check_value("busy_acc", busy, 1);
      if (i == n - 1) begin
        check_value("last_valid", sum_valid, 1);
        check_value("last_data", sum_data, exp_sum);
      end else begin
        check_value("mid_no_valid", sum_valid, 0);
      end
    end

    for (int d = 0; d < ready_delay; d++) begin
      if (inject_ovr && d == 0) begin
        p_valid = 1'b1;
        p_data  = 16'($urandom);
        exp_ovr = 1'b1;
      end
      step();
      p_valid = 1'b0;
      check_value("hold_valid", sum_valid, 1);
      check_value("hold_data", sum_data, exp_sum);
      check_value("hold_ovr", overrun, exp_ovr);
    end

    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    check_value("acc_valid_drop", sum_valid, 0);
    check_value("acc_busy_drop", busy, 0);
    check_value("acc_data_kept", sum_data, exp_sum);
    check_value("acc_ovr", overrun, exp_ovr);
  endtask

  initial begin
    int rl;
    int rd;
    rst_n = 1'b0; start = 1'b0; len = '0; p_valid = 1'b0; p_data = '0; sum_ready = 1'b0;
    exp_ovr = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check_value("rst_busy", busy, 0);
    check_value("rst_valid", sum_valid, 0);
    check_value("rst_data", sum_data, 0);
    check_value("rst_ovr", overrun, 0);

    // Basic run 1..8 -> 36
    prod_q = {};
    for (int i = 1; i <= 8; i++) prod_q.push_back(i);
    do_run(8, 0, 0, 1'b0, 1'b0);

    // Full scale -> 0x7FFF8
    prod_q = {};
    for (int i = 0; i < 8; i++) prod_q.push_back(32'hFFFF);
    do_run(8, 0, 1, 1'b0, 1'b0);

    // Gaps of 2 cycles and 5-cycle backpressure -> 600
    prod_q = {100, 200, 300};
    do_run(3, 2, 5, 1'b0, 1'b0);

    // len = 0
    prod_q = {};
    do_run(0, 0, 2, 1'b0, 1'b0);

    // len = 12 clamps to 8
    prod_q = {};
    for (int i = 0; i < 12; i++) prod_q.push_back(1000 + i);
    do_run(12, 1, 0, 1'b0, 1'b0);

    // Stray product in IDLE sets overrun
    p_valid = 1'b1; p_data = 16'h1234;
    step();
    p_valid = 1'b0;
    check_value("idle_ovr_set", overrun, 1);
    check_value("idle_ovr_busy", busy, 0);
    check_value("idle_ovr_valid", sum_valid, 0);

    // Next start clears it; start during ACC is ignored; stray product in DONE sets it
    prod_q = {11, 22, 33, 44};
    do_run(4, 1, 2, 1'b1, 1'b1);

    // Reset after 4 of 8 products
    prod_q = {};
    for (int i = 0; i < 8; i++) prod_q.push_back(16'h0100 + i);
    start = 1'b1; len = LEN_W'(8);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p_valid = 1'b1; p_data = prod_q[i][15:0];
      step();
    end
    p_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_value("midrst_busy", busy, 0);
    check_value("midrst_valid", sum_valid, 0);
    check_value("midrst_data", sum_data, 0);
    check_value("midrst_ovr", overrun, 0);
    step();
    rst_n = 1'b1;
    step();
    check_value("postrst_valid", sum_valid, 0);
    prod_q = {5, 7};
    do_run(2, 0, 0, 1'b0, 1'b0);

    // Randomised runs
    for (int r = 0; r < 25; r++) begin
      rl = $urandom_range(0, 12);
      rd = $urandom_range(0, 3);
      prod_q = {};
      for (int i = 0; i < 12; i++) prod_q.push_back($urandom_range(0, 65535));
      do_run(rl, 2, rd, 1'($urandom_range(0, 1)), (rd > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
